// File: rtl/alu_exec_pkg.sv
// Shared constants and types for the ALU execution controller.
// Optional multiply support is compiled in with ALU_EXEC_MUL_EN.
package alu_exec_pkg;
  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_SLT = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MUL = 4'd6;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
`ifdef ALU_EXEC_MUL_EN
    S_DONE = 2'd2,
    S_MUL  = 2'd3
`else
    S_DONE = 2'd2
`endif
  } state_t;

  typedef enum logic [2:0] {
    K_LOGIC,
    K_ARITH,
    K_SLT,
    K_MUL,
    K_ILL
  } kind_t;

  function automatic logic [3:0] mk_flags(
    input logic z,
    input logic n,
    input logic c,
    input logic v
  );
    logic [3:0] f;
    f = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction
endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Request/result handshake bundle between a requester and the controller.
// Signal set is independent of ALU_EXEC_MUL_EN.
interface alu_exec_ctrl_if;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  opcode;
  logic [15:0] src_a;
  logic [15:0] src_b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_err;

  modport master (
    output op_valid, opcode, src_a, src_b, res_ready,
    input  op_ready, res_valid, res_data, res_err
  );

  modport slave (
    input  op_valid, opcode, src_a, src_b, res_ready,
    output op_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/alu_exec_decode.sv
// Combinational opcode decoder: ALU operation, b-negate and result kind.
// Opcode 6 decodes as multiply only when ALU_EXEC_MUL_EN is defined.
module alu_exec_decode
  import alu_exec_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] alu_op,
  output logic       bneg,
  output kind_t      kind
);
  always_comb begin
    alu_op = ALU_AND;
    bneg   = 1'b0;
    kind   = K_ILL;
    unique case (1'b1)
      (opcode == OP_AND): kind = K_LOGIC;
      (opcode == OP_OR): begin
        alu_op = ALU_OR;
        kind   = K_LOGIC;
      end
      (opcode == OP_ADD): begin
        alu_op = ALU_ADD;
        kind   = K_ARITH;
      end
      (opcode == OP_SUB),
      (opcode == OP_CMP): begin
        alu_op = ALU_ADD;
        bneg   = 1'b1;
        kind   = K_ARITH;
      end
      (opcode == OP_SLT): begin
        alu_op = ALU_ADD;
        bneg   = 1'b1;
        kind   = K_SLT;
      end
`ifdef ALU_EXEC_MUL_EN
      (opcode == OP_MUL): begin
        alu_op = ALU_ADD;
        kind   = K_MUL;
      end
`endif
      default: kind = K_ILL;
    endcase
  end
endmodule

// File: rtl/alu_exec_ctrl.sv
// Sequencer driving an external 16-bit ALU; handshaked ops in, results out.
// Define ALU_EXEC_MUL_EN to add the 16-cycle shift-add multiply.
module alu_exec_ctrl
  import alu_exec_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_ctrl_if.slave io,
  output logic [15:0]    alu_a,
  output logic [15:0]    alu_b,
  output logic           alu_bnegate,
  output logic [2:0]     alu_operation,
  input  logic [15:0]    alu_result,
  input  logic           alu_zero,
  input  logic           alu_overflow,
  input  logic           alu_carry,
  output logic [3:0]     flags
);
  state_t      state;
  logic [3:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [2:0]  dec_op;
  logic        dec_bneg;
  kind_t       dec_kind;
  logic [15:0] slt_res;

  alu_exec_decode u_dec (
    .opcode (op_q),
    .alu_op (dec_op),
    .bneg   (dec_bneg),
    .kind   (dec_kind)
  );

  assign io.op_ready = (state == S_IDLE);
  assign slt_res = {15'b0, alu_result[15] ^ alu_overflow};

`ifdef ALU_EXEC_MUL_EN
  logic [15:0] acc;
  logic [3:0]  cnt;
  logic [15:0] mul_next;
  // During MUL, a_q is the shifted multiplicand, b_q the shifted multiplier
  assign mul_next = b_q[0] ? alu_result : acc;
`endif

  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    alu_bnegate   = 1'b0;
    alu_operation = ALU_AND;
    unique case (state)
      S_EXEC: begin
        alu_a         = a_q;
        alu_b         = b_q;
        alu_bnegate   = dec_bneg;
        alu_operation = dec_op;
      end
`ifdef ALU_EXEC_MUL_EN
      S_MUL: begin
        if (b_q[0]) begin
          alu_a         = acc;
          alu_b         = a_q;
          alu_operation = ALU_ADD;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      io.res_valid <= 1'b0;
      io.res_data  <= '0;
      io.res_err   <= 1'b0;
      flags        <= '0;
`ifdef ALU_EXEC_MUL_EN
      acc          <= '0;
      cnt          <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (io.op_valid) begin
            op_q  <= io.opcode;
            a_q   <= io.src_a;
            b_q   <= io.src_b;
            state <= S_EXEC;
`ifdef ALU_EXEC_MUL_EN
            if (io.opcode == OP_MUL) begin
              state <= S_MUL;
              acc   <= '0;
              cnt   <= '0;
            end
`endif
          end
        end
        S_EXEC: begin
          state      <= S_DONE;
          io.res_err <= 1'b0;
          unique case (dec_kind)
            K_LOGIC: begin
              io.res_data <= alu_result;
              flags <= mk_flags(alu_zero,
                alu_result[15], 1'b0, 1'b0);
            end
            K_ARITH: begin
              io.res_data <= alu_result;
              flags <= mk_flags(alu_zero,
                alu_result[15], alu_carry,
                alu_overflow);
            end
            K_SLT: begin
              io.res_data <= slt_res;
              flags <= mk_flags(slt_res == '0,
                slt_res[15], alu_carry,
                alu_overflow);
            end
            default: begin
              io.res_data <= '0;
              io.res_err  <= 1'b1;
            end
          endcase
        end
`ifdef ALU_EXEC_MUL_EN
        S_MUL: begin
          acc <= mul_next;
          a_q <= a_q << 1;
          b_q <= b_q >> 1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state       <= S_DONE;
            io.res_data <= mul_next;
            io.res_err  <= 1'b0;
            flags <= mk_flags(mul_next == '0,
              mul_next[15], 1'b0, 1'b0);
          end
        end
`endif
        S_DONE: begin
          // First DONE cycle raises valid; handshake only counts after that
          if (!io.res_valid) begin
            io.res_valid <= 1'b1;
          end else if (io.res_ready) begin
            io.res_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural 16-bit ALU.
// Covers ALU_EXEC_MUL_EN both defined and undefined.
module tb_alu_exec_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_bnegate;
  logic [2:0]  alu_operation;
  logic [15:0] alu_result;
  logic        alu_zero;
  logic        alu_overflow;
  logic        alu_carry;
  logic [3:0]  flags;
  int          tests = 0;
  int          fails = 0;

  alu_exec_ctrl_if bus ();

  alu_exec_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .io            (bus),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_bnegate   (alu_bnegate),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
    .alu_carry     (alu_carry),
    .flags         (flags)
  );

  always #5 clk = ~clk;

  logic [15:0] bx;
  logic [16:0] sum;
  always_comb begin
    bx           = alu_bnegate ? ~alu_b : alu_b;
    sum          = {1'b0, alu_a} + {1'b0, bx} + {16'b0, alu_bnegate};
    alu_result   = 16'h0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_operation)
      3'b000: alu_result = alu_a & bx;
      3'b001: alu_result = alu_a | bx;
      3'b010: begin
        alu_result   = sum[15:0];
        alu_carry    = sum[16];
        alu_overflow = (alu_a[15] == bx[15]) && (sum[15] != alu_a[15]);
      end
      default: alu_result = 16'h0;
    endcase
    alu_zero = (alu_result == 16'h0);
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    bus.opcode   = op;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.op_valid = 1'b1;
    chk("op_ready_before_accept", {15'b0, bus.op_ready}, 16'h1);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input int lat, input logic [15:0] exp_d,
                       input logic exp_e, input logic [3:0] exp_f,
                       input int stall);
    int n;
    issue(op, a, b);
    n = 0;
    while (!bus.res_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 16'(n), 16'(lat));
    chk({tag, "_data"}, bus.res_data, exp_d);
    chk({tag, "_err"}, {15'b0, bus.res_err}, {15'b0, exp_e});
    chk({tag, "_flags"}, {12'b0, flags}, {12'b0, exp_f});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, {15'b0, bus.res_valid}, 16'h1);
      chk({tag, "_hold_data"}, bus.res_data, exp_d);
      chk({tag, "_hold_ready"}, {15'b0, bus.op_ready}, 16'h0);
      chk({tag, "_hold_aluop"}, {13'b0, alu_operation}, 16'h0);
      chk({tag, "_hold_alua"}, alu_a, 16'h0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    chk({tag, "_exit_valid"}, {15'b0, bus.res_valid}, 16'h0);
    chk({tag, "_exit_idle"}, {15'b0, bus.op_ready}, 16'h1);
  endtask

  initial begin
    int k;
    bit seen;
    rst_n         = 1'b0;
    bus.op_valid  = 1'b0;
    bus.opcode    = 4'h0;
    bus.src_a     = 16'h0;
    bus.src_b     = 16'h0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {15'b0, bus.res_valid}, 16'h0);
    chk("rst_data", bus.res_data, 16'h0);
    chk("rst_err", {15'b0, bus.res_err}, 16'h0);
    chk("rst_flags", {12'b0, flags}, 16'h0);
    chk("rst_ready", {15'b0, bus.op_ready}, 16'h1);
    chk("rst_alua", alu_a, 16'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("add_ovf", 4'd2, 16'h7FFF, 16'h0001, 2, 16'h8000, 1'b0, 4'b0101, 0);
    do_op("sub_zero", 4'd3, 16'h0005, 16'h0005, 2, 16'h0000, 1'b0, 4'b1010, 0);
    do_op("slt_neg", 4'd4, 16'hFFFF, 16'h0001, 2, 16'h0001, 1'b0, 4'b0010, 0);
    do_op("and", 4'd0, 16'hF0F0, 16'h3C3C, 2, 16'h3030, 1'b0, 4'b0000, 0);
    do_op("or", 4'd1, 16'h0F00, 16'h8001, 2, 16'h8F01, 1'b0, 4'b0100, 0);
    do_op("cmp", 4'd5, 16'h0003, 16'h0007, 2, 16'hFFFC, 1'b0, 4'b0100, 0);
    do_op("ill9", 4'd9, 16'h1234, 16'h5678, 2, 16'h0000, 1'b1, 4'b0100, 0);
    do_op("ill15", 4'd15, 16'hFFFF, 16'hFFFF, 2, 16'h0000, 1'b1, 4'b0100, 0);
`ifdef ALU_EXEC_MUL_EN
    do_op("mul_3x5", 4'd6, 16'h0003, 16'h0005, 17, 16'h000F, 1'b0, 4'b0000, 0);
    do_op("mul_wrap", 4'd6, 16'h0100, 16'h0100, 17, 16'h0000, 1'b0, 4'b1000, 0);
    k = 8;
`else
    do_op("mul_ill", 4'd6, 16'h0003, 16'h0005, 2, 16'h0000, 1'b1, 4'b0100, 0);
    k = 0;
`endif
    do_op("stall", 4'd2, 16'hFFFF, 16'h0002, 2, 16'h0001, 1'b0, 4'b0010, 5);

    issue(4'd6, 16'h0003, 16'h0005);
    repeat (k) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_valid", {15'b0, bus.res_valid}, 16'h0);
    chk("abort_data", bus.res_data, 16'h0);
    chk("abort_err", {15'b0, bus.res_err}, 16'h0);
    chk("abort_flags", {12'b0, flags}, 16'h0);
    chk("abort_alua", alu_a, 16'h0);
    chk("abort_alub", alu_b, 16'h0);
    chk("abort_aluop", {13'b0, alu_operation}, 16'h0);
    chk("abort_idle", {15'b0, bus.op_ready}, 16'h1);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.res_valid) seen = 1'b1;
    end
    chk("abort_no_valid", {15'b0, seen}, 16'h0);

    do_op("recover", 4'd2, 16'h0002, 16'h0002, 2, 16'h0004, 1'b0, 4'b0000, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
